// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg -- shared definitions for the PE job sequencer.
//
// Contents:
//   state_e          : 3-bit encoding of the seven sequencer states
//   MODE_WIDTH       : width of the PE mode field
//   MODE_PSUM_IN_BIT : mode bit that makes the PE consume input Psum
package pe_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_RES = 3'd2,
        ST_START    = 3'd3,
        ST_RUN      = 3'd4,
        ST_NEXT     = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    localparam int unsigned MODE_WIDTH       = 2;
    localparam int unsigned MODE_PSUM_IN_BIT = 0;

endpackage

// File: rtl/pe_seq_watchdog.sv
// pe_seq_watchdog -- RUN-state watchdog for pe_sequencer.
//
// Counts cycles while `run` is high and clears whenever `run` is low, so the
// count always starts from zero on entry to RUN. `expired` is high in the
// RUN cycle whose closing edge would bring the count to 2^TIMEOUT_WIDTH-1.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   run     : sequencer is in RUN
//   expired : time limit reached this cycle
module pe_seq_watchdog #(
    parameter int unsigned TIMEOUT_WIDTH = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    // All ones minus one: the last count value before the limit.
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    logic [TIMEOUT_WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= count_q + TIMEOUT_WIDTH'(1);
        end else begin
            count_q <= '0;
        end
    end

    assign expired = run && (count_q == CNT_LAST);

endmodule

// File: rtl/pe_sequencer.sv
// pe_sequencer -- job-level controller for one Processing_element and its
// IFMap, Filter, input-Psum and output-Psum circular buffers.
//
// A job descriptor is accepted on cfg_valid & cfg_ready. The PE configuration
// is latched and held, then one pe_start pulse is issued per output row once
// all operand buffers hold data and the output Psum buffer has room. PE done
// pulses are counted until cfg_rows rows are complete, then job_done pulses.
//
// Optional build macro: PE_SEQ_TIMEOUT_EN -- adds a RUN-state watchdog that
// aborts the job (err=1, job_done pulse) if pe_done never arrives.
//
// Ports:
//   clk, rst         : clock (rising edge), asynchronous active-low reset
//   cfg_valid/ready  : descriptor handshake (ready only while idle)
//   cfg_mode         : PE mode, bit0 = consume input Psum
//   cfg_stride       : PE stride
//   cfg_filter_size  : PE filter size
//   cfg_rows         : rows (Start/done pairs) in the job
//   ifmap_valid      : IFMap buffer non-empty
//   filter_valid     : Filter buffer non-empty
//   psum_in_valid    : input Psum buffer non-empty
//   psum_out_ready   : output Psum buffer not full
//   pe_ready         : PE idle
//   pe_done          : PE row-complete pulse (ignored outside RUN)
//   pe_start         : one-cycle Start to the PE
//   pe_mode/stride/filter_size : latched configuration to the PE
//   pe_wr_psum       : PE psum-accumulate enable
//   busy             : job in progress
//   rows_done        : rows completed in current or last job
//   job_done         : one-cycle pulse at job end
//   err              : sticky watchdog abort flag (0 without the macro)
module pe_sequencer
    import pe_seq_pkg::*;
#(
    parameter int unsigned STRIDE_WIDTH      = 2,
    parameter int unsigned FILTER_SIZE_WIDTH = 4,
    parameter int unsigned ROW_CNT_WIDTH     = 6,
    parameter int unsigned TIMEOUT_WIDTH     = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [1:0]                   cfg_mode,
    input  logic [STRIDE_WIDTH-1:0]      cfg_stride,
    input  logic [FILTER_SIZE_WIDTH-1:0] cfg_filter_size,
    input  logic [ROW_CNT_WIDTH-1:0]     cfg_rows,
    input  logic                         ifmap_valid,
    input  logic                         filter_valid,
    input  logic                         psum_in_valid,
    input  logic                         psum_out_ready,
    input  logic                         pe_ready,
    input  logic                         pe_done,
    output logic                         pe_start,
    output logic [1:0]                   pe_mode,
    output logic [STRIDE_WIDTH-1:0]      pe_stride,
    output logic [FILTER_SIZE_WIDTH-1:0] pe_filter_size,
    output logic                         pe_wr_psum,
    output logic                         busy,
    output logic [ROW_CNT_WIDTH-1:0]     rows_done,
    output logic                         job_done,
    output logic                         err
);

    state_e                       state_q, state_d;
    logic [MODE_WIDTH-1:0]        mode_q;
    logic [STRIDE_WIDTH-1:0]      stride_q;
    logic [FILTER_SIZE_WIDTH-1:0] fsize_q;
    logic [ROW_CNT_WIDTH-1:0]     rows_q;
    logic [ROW_CNT_WIDTH-1:0]     rows_done_q;
    logic                         accept;
    logic                         operands_ok;
    logic                         timeout;

    assign accept = cfg_valid && (state_q == ST_IDLE);

    // Input Psum only matters when the mode asks the PE to consume it.
    assign operands_ok = pe_ready && ifmap_valid && filter_valid && psum_out_ready &&
                         (psum_in_valid || !mode_q[MODE_PSUM_IN_BIT]);

`ifdef PE_SEQ_TIMEOUT_EN
    logic wd_expired;
    logic err_q;

    pe_seq_watchdog #(
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .run    (state_q == ST_RUN),
        .expired(wd_expired)
    );

    // A done arriving on the final watchdog cycle still completes the row.
    assign timeout = wd_expired && !pe_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // NOTE: every flop here uses an asynchronous active-low reset so outputs
    // drop to their idle values the moment rst falls, with no clock needed.
    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Descriptor registers change only on an accepted handshake, so the PE
    // configuration holds through the job and keeps its last value in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= '0;
            stride_q <= '0;
            fsize_q  <= '0;
            rows_q   <= '0;
        end else if (accept) begin
            mode_q   <= cfg_mode;
            stride_q <= cfg_stride;
            fsize_q  <= cfg_filter_size;
            rows_q   <= cfg_rows;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_done_q <= '0;
        end else if (state_q == ST_LOAD) begin
            rows_done_q <= '0;
        end else if (state_q == ST_RUN && pe_done) begin
            rows_done_q <= rows_done_q + ROW_CNT_WIDTH'(1);
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cfg_ready  = 1'b0;
        busy       = 1'b1;
        pe_start   = 1'b0;
        pe_wr_psum = 1'b0;
        job_done   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = (rows_q == '0) ? ST_DONE : ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (operands_ok) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                pe_start   = 1'b1;
                pe_wr_psum = mode_q[MODE_PSUM_IN_BIT];
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                pe_wr_psum = mode_q[MODE_PSUM_IN_BIT];
                if (pe_done) begin
                    state_d = ST_NEXT;
                end else if (timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_NEXT: begin
                state_d = (rows_done_q == rows_q) ? ST_DONE : ST_WAIT_RES;
            end
            ST_DONE: begin
                job_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pe_mode        = mode_q;
    assign pe_stride      = stride_q;
    assign pe_filter_size = fsize_q;
    assign rows_done      = rows_done_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer -- directed self-checking bench for pe_sequencer.
//
// A small PE model answers each pe_start with pe_done after done_delay
// cycles (0 = never) and tallies pe_start, job_done and pe_wr_psum cycles.
// Stimulus drives and samples 1 time unit after each rising edge.
module tb_pe_sequencer;

    localparam int unsigned STRIDE_WIDTH      = 2;
    localparam int unsigned FILTER_SIZE_WIDTH = 4;
    localparam int unsigned ROW_CNT_WIDTH     = 6;
`ifdef PE_SEQ_TIMEOUT_EN
    localparam int unsigned TIMEOUT_WIDTH     = 4;
`else
    localparam int unsigned TIMEOUT_WIDTH     = 12;
`endif

    logic                         clk;
    logic                         rst;
    logic                         cfg_valid;
    logic                         cfg_ready;
    logic [1:0]                   cfg_mode;
    logic [STRIDE_WIDTH-1:0]      cfg_stride;
    logic [FILTER_SIZE_WIDTH-1:0] cfg_filter_size;
    logic [ROW_CNT_WIDTH-1:0]     cfg_rows;
    logic                         ifmap_valid;
    logic                         filter_valid;
    logic                         psum_in_valid;
    logic                         psum_out_ready;
    logic                         pe_ready;
    logic                         pe_done;
    logic                         pe_start;
    logic [1:0]                   pe_mode;
    logic [STRIDE_WIDTH-1:0]      pe_stride;
    logic [FILTER_SIZE_WIDTH-1:0] pe_filter_size;
    logic                         pe_wr_psum;
    logic                         busy;
    logic [ROW_CNT_WIDTH-1:0]     rows_done;
    logic                         job_done;
    logic                         err;

    pe_sequencer #(
        .STRIDE_WIDTH     (STRIDE_WIDTH),
        .FILTER_SIZE_WIDTH(FILTER_SIZE_WIDTH),
        .ROW_CNT_WIDTH    (ROW_CNT_WIDTH),
        .TIMEOUT_WIDTH    (TIMEOUT_WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_mode       (cfg_mode),
        .cfg_stride     (cfg_stride),
        .cfg_filter_size(cfg_filter_size),
        .cfg_rows       (cfg_rows),
        .ifmap_valid    (ifmap_valid),
        .filter_valid   (filter_valid),
        .psum_in_valid  (psum_in_valid),
        .psum_out_ready (psum_out_ready),
        .pe_ready       (pe_ready),
        .pe_done        (pe_done),
        .pe_start       (pe_start),
        .pe_mode        (pe_mode),
        .pe_stride      (pe_stride),
        .pe_filter_size (pe_filter_size),
        .pe_wr_psum     (pe_wr_psum),
        .busy           (busy),
        .rows_done      (rows_done),
        .job_done       (job_done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   pass_cnt    = 0;
    int   fail_cnt    = 0;
    int   check_cnt   = 0;
    int   start_cnt   = 0;
    int   job_cnt     = 0;
    int   wr_cnt      = 0;
    int   done_delay  = 20;
    logic inject_done = 1'b0;

    // PE model and event tally, sampled on the falling edge.
    initial begin : pe_model
        int pend;
        pend    = 0;
        pe_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend    = 0;
                pe_done = 1'b0;
            end else begin
                pe_done = inject_done;
                if (pend != 0) begin
                    pend--;
                    if (pend == 0) pe_done = 1'b1;
                end
                if (pe_start === 1'b1) begin
                    start_cnt++;
                    pend = done_delay;
                end
                if (job_done === 1'b1)   job_cnt++;
                if (pe_wr_psum === 1'b1) wr_cnt++;
            end
        end
    end

    initial begin : time_limit
        #500000;
        $display("FAIL time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a descriptor while IDLE; returns 1 unit after the handshake
    // edge, i.e. in the LOAD cycle.
    task automatic send_job(input logic [1:0] mode, input logic [STRIDE_WIDTH-1:0] stride,
                            input logic [FILTER_SIZE_WIDTH-1:0] fsize,
                            input logic [ROW_CNT_WIDTH-1:0] rows);
        @(negedge clk);
        cfg_mode        = mode;
        cfg_stride      = stride;
        cfg_filter_size = fsize;
        cfg_rows        = rows;
        cfg_valid       = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(cfg_ready), 32'd1);
    endtask

    task automatic wait_rows(input string tag, input logic [ROW_CNT_WIDTH-1:0] rows, input int bound);
        int n = 0;
        while (rows_done !== rows && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(rows_done), 32'(rows));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".cfg_ready"},  32'(cfg_ready),      32'd1);
        check({tag, ".pe_start"},   32'(pe_start),       32'd0);
        check({tag, ".pe_wr_psum"}, 32'(pe_wr_psum),     32'd0);
        check({tag, ".pe_mode"},    32'(pe_mode),        32'd0);
        check({tag, ".pe_stride"},  32'(pe_stride),      32'd0);
        check({tag, ".pe_fsize"},   32'(pe_filter_size), 32'd0);
        check({tag, ".busy"},       32'(busy),           32'd0);
        check({tag, ".rows_done"},  32'(rows_done),      32'd0);
        check({tag, ".job_done"},   32'(job_done),       32'd0);
        check({tag, ".err"},        32'(err),            32'd0);
    endtask

    initial begin : stimulus
        int s0, j0, w0;
        rst             = 1'b0;
        cfg_valid       = 1'b0;
        cfg_mode        = '0;
        cfg_stride      = '0;
        cfg_filter_size = '0;
        cfg_rows        = '0;
        ifmap_valid     = 1'b1;
        filter_valid    = 1'b1;
        psum_in_valid   = 1'b1;
        psum_out_ready  = 1'b1;
        pe_ready        = 1'b1;

        #23;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Basic job: mode 3, stride 1, filter 4, three rows, done 20 cycles after Start.
        s0 = start_cnt; j0 = job_cnt; w0 = wr_cnt;
        send_job(2'd3, 2'd1, 4'd4, 6'd3);
        check("basic.load_busy",   32'(busy),           32'd1);
        check("basic.load_ready",  32'(cfg_ready),      32'd0);
        check("basic.load_mode",   32'(pe_mode),        32'd3);
        check("basic.load_stride", 32'(pe_stride),      32'd1);
        check("basic.load_fsize",  32'(pe_filter_size), 32'd4);
        tick();
        check("basic.wait_nostart", 32'(pe_start), 32'd0);
        tick();
        check("basic.first_start", 32'(pe_start),   32'd1);
        check("basic.start_wr",    32'(pe_wr_psum), 32'd1);
        tick();
        check("basic.run_nostart", 32'(pe_start),   32'd0);
        check("basic.run_wr",      32'(pe_wr_psum), 32'd1);
        wait_idle("basic.idle", 200);
        check("basic.starts",    32'(start_cnt - s0), 32'd3);
        check("basic.job_done",  32'(job_cnt - j0),   32'd1);
        check("basic.wr_cycles", 32'(wr_cnt - w0),    32'd63);
        check("basic.rows_done", 32'(rows_done),      32'd3);
        check("basic.idle_wr",   32'(pe_wr_psum),     32'd0);
        check("basic.held_mode", 32'(pe_mode),        32'd3);
        check("basic.err",       32'(err),            32'd0);

        // Backpressure: output Psum full for 15 cycles after the first done.
        s0 = start_cnt; j0 = job_cnt; w0 = wr_cnt;
        send_job(2'd0, 2'd2, 4'd3, 6'd2);
        wait_rows("bp.row1", 6'd1, 100);
        psum_out_ready = 1'b0;
        repeat (15) tick();
        check("bp.held_starts", 32'(start_cnt - s0), 32'd1);
        check("bp.held_busy",   32'(busy),           32'd1);
        psum_out_ready = 1'b1;
        tick();
        check("bp.second_start", 32'(pe_start), 32'd1);
        wait_idle("bp.idle", 100);
        check("bp.starts",    32'(start_cnt - s0), 32'd2);
        check("bp.rows_done", 32'(rows_done),      32'd2);
        check("bp.wr_cycles", 32'(wr_cnt - w0),    32'd0);
        check("bp.job_done",  32'(job_cnt - j0),   32'd1);

        // Input Psum gating, plus a stray pe_done outside RUN.
        s0 = start_cnt;
        psum_in_valid = 1'b0;
        send_job(2'd1, 2'd0, 4'd2, 6'd1);
        repeat (6) tick();
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        tick();
        check("gate.stray_done_rows", 32'(rows_done),      32'd0);
        check("gate.no_start",        32'(start_cnt - s0), 32'd0);
        check("gate.busy",            32'(busy),           32'd1);
        psum_in_valid = 1'b1;
        tick();
        check("gate.start", 32'(pe_start),   32'd1);
        check("gate.wr",    32'(pe_wr_psum), 32'd1);
        wait_idle("gate.idle", 100);
        check("gate.rows_done", 32'(rows_done), 32'd1);

        s0 = start_cnt; w0 = wr_cnt;
        psum_in_valid = 1'b0;
        send_job(2'd2, 2'd0, 4'd2, 6'd1);
        wait_idle("mode2.idle", 100);
        check("mode2.starts",    32'(start_cnt - s0), 32'd1);
        check("mode2.wr_cycles", 32'(wr_cnt - w0),    32'd0);
        check("mode2.rows_done", 32'(rows_done),      32'd1);
        psum_in_valid = 1'b1;

        // Zero rows: job_done two cycles after the handshake, no Start.
        s0 = start_cnt;
        send_job(2'd0, 2'd0, 4'd0, 6'd0);
        check("zero.load_jd", 32'(job_done), 32'd0);
        tick();
        check("zero.job_done",  32'(job_done),  32'd1);
        check("zero.rows_done", 32'(rows_done), 32'd0);
        tick();
        check("zero.ready",    32'(cfg_ready),      32'd1);
        check("zero.jd_low",   32'(job_done),       32'd0);
        check("zero.no_start", 32'(start_cnt - s0), 32'd0);

        // A descriptor offered while busy waits until IDLE.
        s0 = start_cnt; j0 = job_cnt;
        send_job(2'd0, 2'd2, 4'd7, 6'd2);
        cfg_mode        = 2'd3;
        cfg_stride      = 2'd3;
        cfg_filter_size = 4'd9;
        cfg_rows        = 6'd1;
        cfg_valid       = 1'b1;
        repeat (10) tick();
        check("busycfg.mode_kept", 32'(pe_mode), 32'd0);
        wait_idle("busycfg.first_idle", 200);
        check("busycfg.rows_first", 32'(rows_done),      32'd2);
        check("busycfg.fsize_old",  32'(pe_filter_size), 32'd7);
        check("busycfg.jobs_first", 32'(job_cnt - j0),   32'd1);
        tick();
        cfg_valid = 1'b0;
        check("busycfg.second_mode",  32'(pe_mode),        32'd3);
        check("busycfg.second_fsize", 32'(pe_filter_size), 32'd9);
        check("busycfg.second_busy",  32'(cfg_ready),      32'd0);
        wait_idle("busycfg.second_idle", 100);
        check("busycfg.rows_second", 32'(rows_done),      32'd1);
        check("busycfg.starts",      32'(start_cnt - s0), 32'd3);

        // Reset asserted mid-RUN in row 2 of 4.
        send_job(2'd3, 2'd1, 4'd5, 6'd4);
        wait_rows("rstrun.row1", 6'd1, 100);
        repeat (5) tick();
        check("rstrun.pre_wr",   32'(pe_wr_psum), 32'd1);
        check("rstrun.pre_busy", 32'(busy),       32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("rstrun");
        #3;
        rst = 1'b1;
        tick();
        s0 = start_cnt; w0 = wr_cnt;
        send_job(2'd1, 2'd1, 4'd3, 6'd2);
        check("rstrun.new_rows0", 32'(rows_done), 32'd0);
        wait_idle("rstrun.new_idle", 200);
        check("rstrun.new_rows",   32'(rows_done),      32'd2);
        check("rstrun.new_starts", 32'(start_cnt - s0), 32'd2);
        check("rstrun.new_wr",     32'(wr_cnt - w0),    32'd42);

`ifdef PE_SEQ_TIMEOUT_EN
        // Watchdog: row 1 completes, row 2 never gets pe_done.
        begin : timeout_test
            int n;
            done_delay = 5;
            send_job(2'd0, 2'd0, 4'd1, 6'd3);
            wait_rows("wd.row1", 6'd1, 100);
            done_delay = 0;
            n = 0;
            while (pe_start !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check("wd.row2_start", 32'(pe_start), 32'd1);
            n = 0;
            while (job_done !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            check("wd.latency",   32'(n),         32'd16);
            check("wd.err",       32'(err),       32'd1);
            check("wd.rows_part", 32'(rows_done), 32'd1);
            tick();
            check("wd.ready",    32'(cfg_ready), 32'd1);
            check("wd.err_held", 32'(err),       32'd1);
            send_job(2'd0, 2'd0, 4'd0, 6'd0);
            check("wd.err_clear", 32'(err), 32'd0);
            wait_idle("wd.idle", 20);
            done_delay = 20;
        end
`endif

        tick();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/pe_sequencer.md
# pe_sequencer

Job-level controller for one Processing_element and its four circular buffers: IFMap, Filter, input Psum and output Psum. It accepts a job descriptor over a valid/ready handshake and drives the PE configuration (mode, stride, filter size). It issues one Start pulse per output row once every operand buffer holds data and the output Psum buffer can accept data, then counts PE `done` pulses until the requested number of rows is complete.

## Interface
- STRIDE_WIDTH, 2, width of stride field
- FILTER_SIZE_WIDTH, 4, width of filter-size field
- ROW_CNT_WIDTH, 6, width of row count / rows_done
- TIMEOUT_WIDTH, 12, watchdog counter width (used only with PE_SEQ_TIMEOUT_EN)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  job descriptor valid
- cfg_ready  out  1  sequencer idle, descriptor accepted on cfg_valid&cfg_ready
- cfg_mode  in  2  PE mode; bit0 = consume input Psum
- cfg_stride  in  STRIDE_WIDTH  PE stride
- cfg_filter_size  in  FILTER_SIZE_WIDTH  PE filter size
- cfg_rows  in  ROW_CNT_WIDTH  rows (Start/done pairs) in the job
- ifmap_valid  in  1  IFMap buffer non-empty
- filter_valid  in  1  Filter buffer non-empty
- psum_in_valid  in  1  input Psum buffer non-empty
- psum_out_ready  in  1  output Psum buffer not full
- pe_ready  in  1  PE idle
- pe_done  in  1  PE row-complete pulse
- pe_start  out  1  one-cycle Start to PE
- pe_mode  out  2  latched mode
- pe_stride  out  STRIDE_WIDTH  latched stride
- pe_filter_size  out  FILTER_SIZE_WIDTH  latched filter size
- pe_wr_psum  out  1  PE psum-accumulate enable
- busy  out  1  job in progress
- rows_done  out  ROW_CNT_WIDTH  rows completed in current or last job
- job_done  out  1  one-cycle pulse at job end
- err  out  1  sticky watchdog abort flag (constant 0 without macro)

## Operation
- FSM states and transitions:
  - IDLE: cfg_ready=1. On handshake, latch descriptor and go to LOAD.
  - LOAD: drive pe_* config, clear rows_done. If cfg_rows==0, go to DONE; otherwise go to WAIT_RES.
  - WAIT_RES: wait until `pe_ready & ifmap_valid & filter_valid & psum_out_ready & (psum_in_valid | ~pe_mode[0])`, then go to START.
  - START: pe_start=1 for exactly this cycle, then go to RUN.
  - RUN: on pe_done, rows_done+1, then go to NEXT.
  - NEXT: if rows_done==cfg_rows, go to DONE; otherwise go to WAIT_RES.
  - DONE: job_done=1 for one cycle, then go to IDLE.
- pe_wr_psum = pe_mode[0] while in START or RUN; 0 otherwise.
- pe_mode, pe_stride and pe_filter_size are held from LOAD onward. They keep their last values in IDLE.
- rows_done is held after the job for readback.
- busy = state≠IDLE.
- pe_done outside RUN is ignored.
- cfg_valid while busy is ignored; cfg_ready=0, so no loss.
- err is cleared on the next accepted descriptor.

## Timing
- Reset values: cfg_ready=1, pe_start=0, pe_wr_psum=0, pe_mode=0, pe_stride=0, pe_filter_size=0, busy=0, rows_done=0, job_done=0, err=0, state=IDLE.
- Handshake at edge N:
  - LOAD at N+1, WAIT_RES at N+2.
  - Earliest pe_start high in cycle N+3.
  - Config outputs are stable at least 2 cycles before pe_start.
- pe_done in cycle M (RUN): rows_done updated at M+1 (NEXT). Next pe_start no earlier than M+3.
- Last row: job_done high in cycle M+2, cfg_ready high at M+3.
- cfg_rows==0: job_done two cycles after handshake; pe_start never asserts.
- rows_done wraps only if cfg_rows = 2^ROW_CNT_WIDTH−1 and is exceeded, which cannot happen; the NEXT compare terminates first.
- Reset asserted mid-job: all outputs take reset values immediately (asynchronous). The in-flight PE row is abandoned; buffer flush is the system's responsibility.

## Configuration
- PE_SEQ_TIMEOUT_EN defined:
  - Watchdog counts cycles in RUN and clears on entering RUN.
  - If it reaches 2^TIMEOUT_WIDTH−1 without pe_done: set err, pulse job_done, return to IDLE, leave rows_done at its partial value.
- Not defined: no counter; err tied 0; RUN waits indefinitely.

## Structure
- Shared package pe_seq_pkg holds:
  - the state encoding (7 states, 3-bit);
  - mode bit index constants (MODE_PSUM_IN_BIT=0).
- Optional sub-module pe_seq_watchdog (counter + expiry compare), instantiated only under PE_SEQ_TIMEOUT_EN.

## Test plan
- Basic job: mode=3, stride=1, filter_size=4, rows=3, all buffers valid, pe_ready=1, pe_done 20 cycles after each Start. Expect 3 pe_start pulses, pe_wr_psum=1 during each row, rows_done=3, one job_done, cfg_ready back high.
- Backpressure: rows=2, psum_out_ready=0 for 15 cycles after the first done. Expect the second pe_start only after psum_out_ready returns; no extra Start.
- Input Psum gating: mode=1 with psum_in_valid=0 holds in WAIT_RES. Raising psum_in_valid produces pe_start 1 cycle later. With mode=2 and psum_in_valid=0, Start still issues and pe_wr_psum stays 0.
- Zero rows and busy descriptor:
  - rows=0: job_done 2 cycles after handshake, no pe_start.
  - A second cfg_valid during a rows=2 job is not accepted until IDLE.
- Reset mid-RUN: drop rst in row 2 of 4. All outputs go to reset values with no clock edge. A new job after release runs normally from rows_done=0.
- With PE_SEQ_TIMEOUT_EN, TIMEOUT_WIDTH=4: suppress pe_done. Expect err=1 and job_done after 15 RUN cycles, rows_done=partial; err clears on the next accepted descriptor.
